// File: rtl/banked_reg_file_pkg.sv
// Shared types and default widths for the banked register file and its copy sequencer.
package definitions;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_t;

  localparam int DEF_W   = 8;
  localparam int DEF_D   = 4;
  localparam int DEF_NRD = 2;

endpackage

// File: rtl/banked_reg_file_if.sv
// Write, read, and context save/restore signals of the banked register file.
// Reads are combinational; wr_ready drops for the whole duration of a bank copy.
interface banked_reg_file_if
  import definitions::*;
#(
  parameter int W   = DEF_W,
  parameter int D   = DEF_D,
  parameter int NRD = DEF_NRD
) ();

  logic                     write_en;
  logic [D-1:0]             waddr;
  logic [W-1:0]             data_in;
  logic [NRD-1:0][D-1:0]    raddr;
  logic [NRD-1:0][W-1:0]    data_out;
  logic                     save_req;
  logic                     restore_req;
  logic                     wr_ready;
  logic                     ctx_busy;
  logic                     ctx_done;

  modport master (
    output write_en, waddr, data_in, raddr, save_req, restore_req,
    input  data_out, wr_ready, ctx_busy, ctx_done
  );

  modport slave (
    input  write_en, waddr, data_in, raddr, save_req, restore_req,
    output data_out, wr_ready, ctx_busy, ctx_done
  );

endinterface

// File: rtl/banked_reg_file_ctx_seq.sv
// Save/restore sequencer: walks idx over all 2**D entries, one per cycle.
// Requests are only taken in IDLE; those arriving while busy are dropped, not queued.
module ctx_seq
  import definitions::*;
#(
  parameter int D = DEF_D
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          save_req,
  input  logic          restore_req,
  output ctx_state_t    state,
  output logic [D-1:0]  idx,
  output logic          busy,
  output logic          done
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // save has priority when both requests arrive together
          if (save_req) begin
            state <= SAVE;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (restore_req) begin
            state <= RESTORE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          idx <= idx + 1'b1;
          if (&idx) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/banked_reg_file.sv
// Register file with an active and a shadow bank; combinational reads with optional write bypass.
// A save/restore copies one entry per cycle for 2**D cycles, during which writes are refused.
module banked_reg_file
  import definitions::*;
#(
  parameter int             W      = DEF_W,
  parameter int             D      = DEF_D,
  parameter int             NRD    = DEF_NRD,
  parameter logic [NRD-1:0] ZMASK  = NRD'(1),
  parameter int             BYPASS = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  banked_reg_file_if.slave   bus
);

  localparam int DEPTH = 1 << D;

  logic [W-1:0] active [DEPTH];
  logic [W-1:0] shadow [DEPTH];

  ctx_state_t   state;
  logic [D-1:0] idx;
  logic         busy;
  logic         done;
  logic         wr_acc;

  ctx_seq #(.D(D)) u_ctx_seq (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .save_req    (bus.save_req),
    .restore_req (bus.restore_req),
    .state       (state),
    .idx         (idx),
    .busy        (busy),
    .done        (done)
  );

  assign bus.wr_ready = !busy;
  assign bus.ctx_busy = busy;
  assign bus.ctx_done = done;
  assign wr_acc       = bus.write_en && !busy;

  // Writes and bank copies never coincide: wr_acc is low whenever the sequencer is busy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        active[bus.waddr] <= bus.data_in;
      end
      if (state == SAVE) begin
        shadow[idx] <= active[idx];
      end
      if (state == RESTORE) begin
        active[idx] <= shadow[idx];
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.data_out[i] = active[bus.raddr[i]];
      if ((BYPASS != 0) && wr_acc && (bus.waddr == bus.raddr[i])) begin
        bus.data_out[i] = bus.data_in;
      end
      if (ZMASK[i] && (bus.raddr[i] == '0)) begin
        bus.data_out[i] = '0;
      end
    end
  end

endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the data path width.
REQ-002 The module SHALL have parameter D, default 4, giving the pointer width, so the file holds 2**D registers.
REQ-003 The module SHALL have parameter NRD, default 2, giving the number of read ports.
REQ-004 The module SHALL have parameter ZMASK, default NRD'b01, where bit i set means port i returns zero for address 0.
REQ-005 The module SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-006 The module SHALL have port CLK, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 The module SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port write_en, input, 1 bit: write request.
REQ-009 The module SHALL have port waddr, input, D bits: write address.
REQ-010 The module SHALL have port data_in, input, W bits: write data.
REQ-011 The module SHALL have port raddr, input, NRD x D bits: read addresses.
REQ-012 The module SHALL have port data_out, output, NRD x W bits: read data.
REQ-013 The module SHALL have port save_req, input, 1 bit: copy the active bank to the shadow bank.
REQ-014 The module SHALL have port restore_req, input, 1 bit: copy the shadow bank to the active bank.
REQ-015 The module SHALL have port wr_ready, output, 1 bit: high when writes are accepted.
REQ-016 The module SHALL have port ctx_busy, output, 1 bit: high while a save or restore is in progress.
REQ-017 The module SHALL have port ctx_done, output, 1 bit: one-cycle pulse when a save or restore completes.

Function
REQ-018 Reads SHALL be combinational: data_out[i] = active[raddr[i]], except it SHALL be 0 when ZMASK[i] is set and raddr[i]==0.
REQ-019 A write SHALL be accepted when write_en && wr_ready, updating active[waddr] at the next edge; address 0 SHALL be writable.
REQ-020 With BYPASS=1, an accepted write with waddr==raddr[i] SHALL drive data_in on data_out[i] in the same cycle, with blanking per REQ-018 still applied.
REQ-021 wr_ready SHALL equal !ctx_busy; writes while not ready SHALL be dropped with no state change.
REQ-022 The FSM SHALL have states IDLE, SAVE and RESTORE, plus an index counter idx of D bits.
REQ-023 In IDLE, save_req SHALL go to SAVE with idx=0; otherwise restore_req SHALL go to RESTORE with idx=0; save SHALL win if both are asserted.
REQ-024 In SAVE, each edge SHALL perform shadow[idx]<=active[idx] and idx++; in RESTORE, each edge SHALL perform active[idx]<=shadow[idx] and idx++.
REQ-025 On the edge where idx==2**D-1, the FSM SHALL return to IDLE and assert ctx_done for exactly the following cycle.
REQ-026 ctx_busy SHALL be high exactly while state!=IDLE, i.e. 2**D cycles per operation (16 at defaults).
REQ-027 save_req and restore_req while busy SHALL be ignored and not queued.
REQ-028 Reads during RESTORE SHALL return the active-bank contents, whether already restored or not, without stalling.
REQ-029 A back-to-back request SHALL be accepted in the cycle ctx_done is high, because the state is IDLE in that cycle.

Reset
REQ-030 RST_N low SHALL immediately clear all active and shadow registers, set state=IDLE, idx=0 and ctx_done=0.
REQ-031 After reset, data_out SHALL be 0, wr_ready=1 and ctx_busy=0.
REQ-032 Reset asserted mid-SAVE or mid-RESTORE SHALL abort the operation with no ctx_done pulse.

Structure
REQ-033 The FSM state enum ctx_state_t (IDLE/SAVE/RESTORE) SHALL live in package definitions.
REQ-034 The shared default widths SHALL live in package definitions.
REQ-035 The copy sequencer SHALL be one sub-module, ctx_seq (FSM, idx, busy, done), and the register arrays SHALL stay in the top level.

Verification
REQ-036 Reset, then write 0x5A to r3; on the next cycle, reading raddr[1]=3 SHALL return 0x5A.
REQ-037 Write 0x77 to r0; raddr[0]=0 SHALL read 0 and raddr[1]=0 SHALL read 0x77.
REQ-038 write_en with waddr=5, data 0xC3, and raddr[1]=5 in the same cycle SHALL give data_out[1]=0xC3 combinationally.
REQ-039 Fill r1..r15 with the value i, save, overwrite r1..r15 with 0xFF, then restore: ctx_busy SHALL be high for 16 cycles each time, ctx_done SHALL pulse once each time, and afterwards r7==7.
REQ-040 A write_en during SAVE SHALL be dropped, and the target SHALL keep its old value.
REQ-041 Pulsing RST_N low at idx=8 of SAVE SHALL leave all registers at 0, ctx_busy=0 and no ctx_done pulse.
REQ-042 save_req and restore_req asserted together SHALL enter SAVE.
